grid_scan_driver: RTL and testbench

- Consumer end of the 16x16 game grid. Takes the combinational grid bitmap and drives a row-multiplexed LED matrix through a serial column shift register.
- The shift register is 74HC595-style: sclk, sdata and a latch strobe, plus a 4-bit row select.
- The grid is snapshotted once per frame so the display never tears. The block scans rows 0..15 continuously while enabled.

---
 rtl/grid_scan_driver.sv | 147 ++++++++++++++
 tb/tb_grid_scan_driver.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_scan_driver.sv
`timescale 1ns/1ps
// Row-multiplexed LED matrix driver: snapshots a 16x16 bitmap once per frame and
// streams each row MSB-first into a 74HC595-style column register.
module grid_scan_driver #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned DWELL_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0][15:0] grid,
  input  logic              en,
  output logic              sclk,
  output logic              sdata,
  output logic              latch,
  output logic [3:0]        row_sel,
  output logic              frame_done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_SHIFT_LO = 3'd2;
  localparam logic [2:0] S_SHIFT_HI = 3'd3;
  localparam logic [2:0] S_LATCH    = 3'd4;
  localparam logic [2:0] S_DWELL    = 3'd5;

  localparam logic [7:0]  DIV_RELOAD   = 8'(CLK_DIV - 1);
  localparam logic [15:0] DWELL_RELOAD = 16'(DWELL_CYCLES - 1);

  logic [2:0]        state;
  logic [3:0]        row_cnt;
  logic [3:0]        bit_cnt;
  logic [15:0]       shift;
  logic [15:0][15:0] fbuf;
  logic [7:0]        div_cnt;
  logic [15:0]       dwell_cnt;

  logic [15:0] row_word;
  logic        div_last;
  logic        dwell_last;

  // Row 0 reads the live grid because the snapshot is taken in the same cycle.
  assign row_word   = (row_cnt == 4'd0) ? grid[0] : fbuf[row_cnt];
  assign div_last   = (div_cnt == 8'd0);
  assign dwell_last = (dwell_cnt == 16'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      row_cnt    <= 4'd0;
      bit_cnt    <= 4'd0;
      shift      <= 16'd0;
      fbuf       <= '0;
      div_cnt    <= 8'd0;
      dwell_cnt  <= 16'd0;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      latch      <= 1'b0;
      row_sel    <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          sclk    <= 1'b0;
          sdata   <= 1'b0;
          latch   <= 1'b0;
          row_sel <= 4'd0;
          if (en) state <= S_LOAD;
        end

        S_LOAD: begin
          if (row_cnt == 4'd0) fbuf <= grid;
          shift   <= row_word;
          bit_cnt <= 4'd0;
          sdata   <= row_word[15];
          sclk    <= 1'b0;
          div_cnt <= DIV_RELOAD;
          state   <= S_SHIFT_LO;
        end

        S_SHIFT_LO: begin
          if (div_last) begin
            sclk    <= 1'b1;
            div_cnt <= DIV_RELOAD;
            state   <= S_SHIFT_HI;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        S_SHIFT_HI: begin
          if (div_last) begin
            shift   <= {shift[14:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
            sclk    <= 1'b0;
            div_cnt <= DIV_RELOAD;
            if (bit_cnt == 4'd15) begin
              latch   <= 1'b1;
              sdata   <= 1'b0;
              row_sel <= row_cnt;
              state   <= S_LATCH;
            end else begin
              // Next bit is presented together with the falling sclk edge.
              sdata <= shift[14];
              state <= S_SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        S_LATCH: begin
          if (div_last) begin
            latch     <= 1'b0;
            dwell_cnt <= DWELL_RELOAD;
            state     <= S_DWELL;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        S_DWELL: begin
          if (dwell_last) begin
            if (row_cnt != 4'd15) begin
              row_cnt <= row_cnt + 4'd1;
              state   <= S_LOAD;
            end else begin
              row_cnt    <= 4'd0;
              frame_done <= 1'b1;
              if (en) begin
                state <= S_LOAD;
              end else begin
                row_sel <= 4'd0;
                state   <= S_IDLE;
              end
            end
          end else begin
            dwell_cnt <= dwell_cnt - 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_scan_driver.sv
`timescale 1ns/1ps
// Directed bench for grid_scan_driver: default-parameter instance plus a
// CLK_DIV=1 / DWELL_CYCLES=1 instance for fast-timing checks.
module tb_grid_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, reset2_n, en, en2;
  logic [15:0][15:0] grid;
  logic              sclk, sdata, latch, frame_done;
  logic [3:0]        row_sel;
  logic              sclk2, sdata2, latch2, frame_done2;
  logic [3:0]        row_sel2;

  grid_scan_driver dut (
    .clk(clk), .reset_n(reset_n), .grid(grid), .en(en),
    .sclk(sclk), .sdata(sdata), .latch(latch), .row_sel(row_sel), .frame_done(frame_done)
  );

  grid_scan_driver #(.CLK_DIV(1), .DWELL_CYCLES(1)) dut2 (
    .clk(clk), .reset_n(reset2_n), .grid(grid), .en(en2),
    .sclk(sclk2), .sdata(sdata2), .latch(latch2), .row_sel(row_sel2), .frame_done(frame_done2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor for the default instance: rebuilds each shifted row word.
  logic [15:0] sh = 16'd0;
  int          nb = 0, lw = 0;
  logic        sclk_q = 1'b0, latch_q = 1'b0;
  logic [15:0] cap_word[$];
  logic [3:0]  cap_row[$];
  int          cap_nb[$];
  int          lat_w[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      nb = 0;
    end else begin
      if (sclk && !sclk_q) begin
        sh = {sh[14:0], sdata};
        nb++;
      end
      if (latch && !latch_q) begin
        cap_word.push_back(sh);
        cap_row.push_back(row_sel);
        cap_nb.push_back(nb);
        nb = 0;
        lw = 0;
      end
      if (latch) lw++;
      if (!latch && latch_q) lat_w.push_back(lw);
    end
    sclk_q  = sclk;
    latch_q = latch;
  end

  // Monitor for the fast instance: event timestamps.
  logic [15:0] sh2 = 16'd0;
  logic        sclk2_q = 1'b0, latch2_q = 1'b0;
  int          lw2 = 0;
  int          rise2[$];
  int          lat2_t[$];
  logic [3:0]  lat2_row[$];
  logic [15:0] lat2_word[$];
  int          lat2_w[$];
  int          fd2[$];

  always @(negedge clk) begin
    if (sclk2 && !sclk2_q) begin
      rise2.push_back(cyc);
      sh2 = {sh2[14:0], sdata2};
    end
    if (latch2 && !latch2_q) begin
      lat2_t.push_back(cyc);
      lat2_row.push_back(row_sel2);
      lat2_word.push_back(sh2);
      lw2 = 0;
    end
    if (latch2) lw2++;
    if (!latch2 && latch2_q) lat2_w.push_back(lw2);
    if (frame_done2) fd2.push_back(cyc);
    sclk2_q  = sclk2;
    latch2_q = latch2;
  end

  task automatic wait_fd(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (frame_done) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_sclk_hi(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sclk) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("sclk_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_caps(input int n, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cap_word.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_until_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] img_a[16];
  logic [15:0] img_b[16];
  logic [15:0] img_c[16];
  int t_en, t_rise, e1, e2, e3, e4, t5, idx2, idx3, idx4, idx5;
  bit found;

  initial begin
    for (int r = 0; r < 16; r++) begin
      img_a[r] = (r == 5) ? 16'h1000 : 16'h0000;
      img_b[r] = 16'h0F00 | 16'(r);
      img_c[r] = 16'hC3C3 ^ 16'(r * 16'h0101);
    end

    // Reset state
    reset_n = 1'b0; reset2_n = 1'b0; en = 1'b0; en2 = 1'b0; grid = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_sdata", {31'd0, sdata}, 32'd0);
    chk("rst_latch", {31'd0, latch}, 32'd0);
    chk("rst_row_sel", {28'd0, row_sel}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    reset_n = 1'b1; reset2_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_sclk", {31'd0, sclk}, 32'd0);

    // Row 0 = 8001, first sclk rise 5 cycles after LOAD entry
    grid[0] = 16'h8001;
    en = 1'b1; en2 = 1'b1;
    t_en = cyc;
    wait_sclk_hi(20, t_rise);
    chk("first_rise_latency", 32'(t_rise - (t_en + 1)), 32'd5);
    wait_caps(1, 300);
    repeat (6) @(negedge clk);
    chk("row0_word", {16'd0, cap_word[0]}, 32'h8001);
    chk("row0_bits", 32'(cap_nb[0]), 32'd16);
    chk("row0_row_sel", {28'd0, cap_row[0]}, 32'd0);
    chk("row0_latch_width", 32'(lat_w[0]), 32'd4);

    // Single pixel at row 5, column 3; set mid-frame so frame 1 keeps old image
    grid = '0;
    grid[5][12] = 1'b1;
    wait_fd(3400, e1);
    chk("frame1_period", 32'(e1 - (t_en + 1)), 32'd3152);
    chk("frame1_row5_old", {16'd0, cap_word[5]}, 32'h0000);
    idx2 = cap_word.size();
    chk("frame1_rows", 32'(idx2), 32'd16);
    en2 = 1'b0;
    wait_fd(3400, e2);
    chk("frame2_period", 32'(e2 - e1), 32'd3152);
    @(negedge clk);
    chk("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
    for (int r = 0; r < 16; r++) begin
      chk($sformatf("pix_row%0d_word", r), {16'd0, cap_word[idx2 + r]}, {16'd0, img_a[r]});
      chk($sformatf("pix_row%0d_sel", r), {28'd0, cap_row[idx2 + r]}, 32'(r));
    end

    // Change grid while row 7 of frame 3 is shifting
    idx3 = idx2 + 16;
    wait_until_cyc(e2 + 7 * 197 + 20);
    for (int r = 0; r < 16; r++) grid[r] = img_b[r];
    wait_fd(3400, e3);
    chk("frame3_period", 32'(e3 - e2), 32'd3152);
    for (int r = 7; r < 16; r++)
      chk($sformatf("midchg_row%0d_old", r), {16'd0, cap_word[idx3 + r]}, {16'd0, img_a[r]});
    idx4 = idx3 + 16;
    wait_caps(idx4 + 1, 300);
    chk("next_frame_row0_new", {16'd0, cap_word[idx4]}, 32'h0F00);
    chk("next_frame_row0_sel", {28'd0, cap_row[idx4]}, 32'd0);

    // Drop en during row 9: frame completes then IDLE
    wait_until_cyc(e3 + 9 * 197 + 50);
    en = 1'b0;
    wait_fd(3400, e4);
    chk("frame4_period", 32'(e4 - e3), 32'd3152);
    for (int r = 9; r < 16; r++) begin
      chk($sformatf("drop_row%0d_word", r), {16'd0, cap_word[idx4 + r]}, {16'd0, img_b[r]});
      chk($sformatf("drop_row%0d_sel", r), {28'd0, cap_row[idx4 + r]}, 32'(r));
    end
    @(negedge clk);
    chk("idle_sclk_after", {31'd0, sclk}, 32'd0);
    chk("idle_sdata_after", {31'd0, sdata}, 32'd0);
    chk("idle_latch_after", {31'd0, latch}, 32'd0);
    chk("idle_row_sel_after", {28'd0, row_sel}, 32'd0);
    chk("idle_frame_done_after", {31'd0, frame_done}, 32'd0);
    repeat (300) @(negedge clk);
    chk("idle_no_rows", 32'(cap_word.size()), 32'(idx4 + 16));
    en = 1'b1;
    t5 = cyc;
    wait_sclk_hi(20, t_rise);
    chk("restart_rise_latency", 32'(t_rise - t5), 32'd6);

    // Async reset mid SHIFT_HI of row 3 with sdata high
    wait_until_cyc(t5 + 1 + 3 * 197 + 2);
    found = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (sclk && sdata) begin
        found = 1'b1;
        break;
      end
    end
    chk("pre_rst_found_shift_hi", {31'd0, found}, 32'd1);
    chk("pre_rst_row_sel", {28'd0, row_sel}, 32'd2);
    reset_n = 1'b0;
    #1;
    chk("async_rst_sclk", {31'd0, sclk}, 32'd0);
    chk("async_rst_sdata", {31'd0, sdata}, 32'd0);
    chk("async_rst_latch", {31'd0, latch}, 32'd0);
    chk("async_rst_row_sel", {28'd0, row_sel}, 32'd0);
    for (int r = 0; r < 16; r++) grid[r] = img_c[r];
    repeat (3) @(negedge clk);
    idx5 = cap_word.size();
    reset_n = 1'b1;
    wait_caps(idx5 + 2, 600);
    chk("post_rst_row0_word", {16'd0, cap_word[idx5]}, 32'hC3C3);
    chk("post_rst_row0_sel", {28'd0, cap_row[idx5]}, 32'd0);
    chk("post_rst_row0_bits", 32'(cap_nb[idx5]), 32'd16);
    chk("post_rst_row1_word", {16'd0, cap_word[idx5 + 1]}, 32'hC2C2);
    chk("post_rst_row1_sel", {28'd0, cap_row[idx5 + 1]}, 32'd1);

    // Fast instance: CLK_DIV=1, DWELL_CYCLES=1
    chk("fast_first_rise", 32'(rise2[0] - (t_en + 1)), 32'd2);
    for (int k = 0; k < 15; k++)
      chk($sformatf("fast_sclk_period%0d", k), 32'(rise2[k + 1] - rise2[k]), 32'd2);
    chk("fast_row_rise_gap", 32'(rise2[16] - rise2[0]), 32'd35);
    chk("fast_row0_word", {16'd0, lat2_word[0]}, 32'h8001);
    chk("fast_latch_width", 32'(lat2_w[0]), 32'd1);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("fast_row_sel%0d", i), {28'd0, lat2_row[i]}, 32'(i % 16));
      if (i > 0)
        chk($sformatf("fast_row_period%0d", i), 32'(lat2_t[i] - lat2_t[i - 1]), 32'd35);
    end
    chk("fast_frame0", 32'(fd2[0] - (t_en + 1)), 32'd560);
    chk("fast_frame1", 32'(fd2[1] - fd2[0]), 32'd560);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
